dh_modexp: RTL and testbench

- Sequential modular exponentiation engine: computes result = base^expo mod p by left-to-right square-and-multiply.
- Each modular product is formed by a bit-serial interleaved shift-add-reduce multiplier, so no divider is used.
- It is the producer side of the key-exchange datapath: it generates the public values g^x mod p and the shared secret R^x mod p that the modular-reduction stage consumes.
- Handshake: start/busy/done.

---
 rtl/dh_pkg.sv | 15 +
 rtl/dh_modmul.sv | 57 +++++
 rtl/dh_modexp.sv | 136 +++++++++++++
 tb/tb_dh_modexp.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dh_pkg.sv
// rtl/dh_pkg.sv - shared state encoding and default widths for the modexp engine
package dh_pkg;

    localparam int DH_W  = 32;
    localparam int DH_EW = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/dh_modmul.sv
// rtl/dh_modmul.sv - W-cycle interleaved shift-add-reduce modular multiplier (x*y mod p)
module dh_modmul
    import dh_pkg::*;
#(
    parameter int W = DH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] p,
    output logic         rdy,
    output logic [W-1:0] prod
);

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic          active;
    logic [W-1:0]  ysh;
    logic [W-1:0]  t;
    logic [W-1:0]  t_in;
    logic [W:0]    t_dbl;
    logic [W:0]    t_add;
    logic          ybit;

    // The go cycle performs the first iteration itself, so a multiply occupies
    // exactly W cycles and prod/rdy are presented combinationally on the last one.
    always_comb begin
        t_in  = go ? '0 : t;
        idx   = go ? '0 : cnt;
        ybit  = go ? y[W-1] : ysh[W-1];
        t_dbl = {t_in, 1'b0};
        if (t_dbl >= {1'b0, p}) t_dbl = t_dbl - {1'b0, p};
        t_add = t_dbl + (ybit ? {1'b0, x} : '0);
        if (t_add >= {1'b0, p}) t_add = t_add - {1'b0, p};
        prod  = t_add[W-1:0];
        rdy   = (go || active) && (idx == CW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else begin
            active <= (go || active) && !rdy;
            if (go || active) begin
                t   <= prod;
                cnt <= idx + 1'b1;
                ysh <= (go ? y : ysh) << 1;
            end
        end
    end

endmodule

// File: rtl/dh_modexp.sv
// rtl/dh_modexp.sv - left-to-right square-and-multiply base^expo mod p engine
// Option: DH_MODEXP_CONST_TIME_EN runs MUL on every exponent bit for fixed latency.
module dh_modexp
    import dh_pkg::*;
#(
    parameter int W  = DH_W,
    parameter int EW = DH_EW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] expo,
    input  logic [W-1:0]  p,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  result
);

    localparam int BW = (EW > 1) ? $clog2(EW) : 1;

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  b;
    logic [W-1:0]  pr;
    logic [EW-1:0] e;
    logic [BW-1:0] bcnt;
    logic          mgo;
    logic [W-1:0]  mx;
    logic [W-1:0]  my;
    logic [W-1:0]  prod;
    logic [W-1:0]  acc_new;
    logic          rdy;
    logic          ebit;
    logic          last;
    logic          mul_next;
    logic          take;

    assign ebit = e[EW-1];
    assign last = (bcnt == '0);

`ifdef DH_MODEXP_CONST_TIME_EN
    assign mul_next = 1'b1;
    assign take     = ebit;
`else
    assign mul_next = ebit;
    assign take     = 1'b1;
`endif

    assign acc_new = (state == MUL && !take) ? acc : prod;

    // LOAD reduces an arbitrary base as 1*base, so only x needs to be below p.
    always_comb begin
        mx = acc;
        my = acc;
        case (state)
            LOAD: begin
                mx = W'(1);
                my = b;
            end
            MUL: my = b;
            default: ;
        endcase
    end

    dh_modmul #(.W(W)) u_modmul (
        .clk  (clk),
        .rst  (rst),
        .go   (mgo),
        .x    (mx),
        .y    (my),
        .p    (pr),
        .rdy  (rdy),
        .prod (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= W'(1);
            mgo    <= 1'b0;
        end else begin
            mgo  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pr   <= p;
                    b    <= base;
                    e    <= expo;
                    acc  <= W'(1);
                    bcnt <= BW'(EW - 1);
                    if (p < W'(2)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        err    <= (p == '0);
                        result <= '0;
                    end else begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        mgo   <= 1'b1;
                    end
                end
                LOAD: if (rdy) begin
                    b     <= prod;
                    state <= SQR;
                    mgo   <= 1'b1;
                end
                SQR, MUL: if (rdy) begin
                    acc <= acc_new;
                    if (state == SQR && mul_next) begin
                        state <= MUL;
                        mgo   <= 1'b1;
                    end else if (last) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        err    <= 1'b0;
                        result <= acc_new;
                    end else begin
                        e     <= e << 1;
                        bcnt  <= bcnt - 1'b1;
                        state <= SQR;
                        mgo   <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dh_modexp.sv
// tb/tb_dh_modexp.sv - randomized self-checking bench for dh_modexp against an arithmetic model
module tb_dh_modexp;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base;
    logic [7:0] expo;
    logic [7:0] p;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;

    int n_checks = 0;
    int n_errors = 0;

    dh_modexp #(.W(8), .EW(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .base   (base),
        .expo   (expo),
        .p      (p),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_modexp(input int bs, input int ex, input int pm);
        longint r;
        longint bb;
        if (pm < 2) return 8'd0;
        r  = 1;
        bb = bs % pm;
        for (int i = 7; i >= 0; i--) begin
            r = (r * r) % pm;
            if (((ex >> i) & 1) == 1) r = (r * bb) % pm;
        end
        return r[7:0];
    endfunction

    function automatic int ref_latency(input int ex, input int pm);
        if (pm < 2) return 1;
`ifdef DH_MODEXP_CONST_TIME_EN
        return 8 * (1 + 2 * 8) + 1;
`else
        return 8 * (1 + 8 + $countones(ex[7:0])) + 1;
`endif
    endfunction

    // Starts an operation now (accepted at the next edge) and returns the done cycle
    // index relative to that edge; optionally pokes start with other operands mid-run.
    task automatic run_op(input logic [7:0] bs, input logic [7:0] ex, input logic [7:0] pm,
                          input int poke_at, output int lat,
                          output logic [7:0] res, output logic er);
        base  = bs;
        expo  = ex;
        p     = pm;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        if (!done) check("busy_on", busy, 1);
        while (!done && lat < 400) begin
            if (lat == poke_at) begin
                start = 1'b1;
                base  = ~bs;
                expo  = 8'hff;
                p     = 8'd200;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        res   = result;
        er    = err;
        check("done_seen", done, 1);
        check("busy_in_done", busy, 0);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
    endtask

    task automatic op_check(input string tag, input logic [7:0] bs, input logic [7:0] ex,
                            input logic [7:0] pm, input int poke_at);
        int         lat;
        logic [7:0] res;
        logic       er;
        run_op(bs, ex, pm, poke_at, lat, res, er);
        check({tag, "_result"}, res, ref_modexp(bs, ex, pm));
        check({tag, "_err"}, er, (pm == 0));
        check({tag, "_latency"}, lat, ref_latency(ex, pm));
    endtask

    initial begin
        int extra;
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        expo  = '0;
        p     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        op_check("basic", 8'd5, 8'd3, 8'd23, 0);
        op_check("unreduced", 8'd30, 8'd1, 8'd23, 0);
        op_check("expo0", 8'd9, 8'd0, 8'd23, 0);
        op_check("p0", 8'd7, 8'd5, 8'd0, 0);
        op_check("p1", 8'd7, 8'd5, 8'd1, 0);
        op_check("after_err", 8'd2, 8'd8, 8'd255, 0);
        op_check("expo_ff", 8'd255, 8'hff, 8'd254, 0);

        op_check("busy_poke", 8'd5, 8'd3, 8'd23, 20);
        extra = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("no_extra_done", extra, 0);
        check("idle_after_poke", busy, 0);

        base  = 8'd5;
        expo  = 8'd3;
        p     = 8'd23;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 1);
        rst = 1'b0;
        op_check("after_rst", 8'd5, 8'd3, 8'd23, 0);

        for (int k = 0; k < 200; k++) begin
            logic [7:0] rb;
            logic [7:0] re;
            logic [7:0] rp;
            rb = 8'($urandom_range(0, 255));
            re = 8'($urandom_range(0, 255));
            rp = 8'($urandom_range(2, 255));
            op_check("rand", rb, re, rp, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
